// File: rtl/axis_crc_framer.sv
// axis_crc_framer: AXI-Stream pass-through that appends an MSB-first CRC trailer to every packet.
// Optional packet counter output pkt_cnt_o is compiled in by defining AXIS_CRC_FRAMER_STATS_EN.
module axis_crc_framer #(
    parameter int DATA_WIDTH = 8,
    parameter int CRC_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [CRC_WIDTH-1:0]  poly_i,
    input  logic [CRC_WIDTH-1:0]  init_i,
    input  logic [CRC_WIDTH-1:0]  xorout_i,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [CRC_WIDTH-1:0]  crc_o,
    output logic                  crc_valid_o
`ifdef AXIS_CRC_FRAMER_STATS_EN
    ,
    output logic [31:0]           pkt_cnt_o
`endif
);

    localparam int NCRC = (CRC_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int PADW = NCRC * DATA_WIDTH;
    localparam int CNTW = $clog2(NCRC + 1);

    typedef enum logic [1:0] {IDLE, DATA, CRC} state_t;

    state_t                state_q, state_d;
    logic [CRC_WIDTH-1:0]  crc_q, crc_d;
    logic [CRC_WIDTH-1:0]  poly_q, poly_d;
    logic [CRC_WIDTH-1:0]  xorout_q, xorout_d;
    logic [CRC_WIDTH-1:0]  crc_out_q, crc_out_d;
    logic                  crc_valid_q, crc_valid_d;
    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  m_last_q, m_last_d;
    logic [CNTW-1:0]       cnt_q, cnt_d;

    logic                  load_en;
    logic                  s_ready;
    logic                  s_hs;
    logic                  first_beat;
    logic [CRC_WIDTH-1:0]  poly_eff;
    logic [CRC_WIDTH-1:0]  xorout_eff;
    logic [CRC_WIDTH-1:0]  crc_base;
    logic [CRC_WIDTH-1:0]  crc_upd;
    logic [PADW-1:0]       crc_pad;
    logic [PADW-1:0]       crc_shift;
    logic [DATA_WIDTH-1:0] crc_beat;

    // Galois LFSR, one input bit per iteration, MSB of the beat first.
    function automatic logic [CRC_WIDTH-1:0] crc_step(
        input logic [CRC_WIDTH-1:0]  crc_in,
        input logic [DATA_WIDTH-1:0] data,
        input logic [CRC_WIDTH-1:0]  poly
    );
        logic [CRC_WIDTH-1:0] c;
        logic                 fb;
        c = crc_in;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            fb = c[CRC_WIDTH-1] ^ data[i];
            c  = {c[CRC_WIDTH-2:0], 1'b0} ^ (fb ? poly : '0);
        end
        return c;
    endfunction

    always_comb begin
        load_en    = !m_valid_q || m_axis_tready;
        s_ready    = rstn_i && (state_q != CRC) && load_en;
        s_hs       = s_ready && s_axis_tvalid;
        first_beat = (state_q == IDLE);
        // The first beat of a packet uses the live configuration; later beats use the sampled copy.
        poly_eff   = first_beat ? poly_i   : poly_q;
        xorout_eff = first_beat ? xorout_i : xorout_q;
        crc_base   = first_beat ? init_i   : crc_q;
        crc_upd    = crc_step(crc_base, s_axis_tdata, poly_eff);
        // Left-justify the final CRC so the last beat is zero-padded in its LSBs.
        crc_pad    = PADW'(crc_out_q) << (PADW - CRC_WIDTH);
        crc_shift  = crc_pad << (int'(cnt_q) * DATA_WIDTH);
        crc_beat   = crc_shift[PADW-1 -: DATA_WIDTH];
    end

    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        poly_d      = poly_q;
        xorout_d    = xorout_q;
        crc_out_d   = crc_out_q;
        crc_valid_d = 1'b0;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        m_last_d    = m_last_q;
        cnt_d       = cnt_q;

        if (load_en) begin
            m_valid_d = 1'b0;
        end

        case (state_q)
            IDLE, DATA: begin
                if (s_hs) begin
                    m_valid_d = 1'b1;
                    m_data_d  = s_axis_tdata;
                    m_last_d  = 1'b0;
                    crc_d     = crc_upd;
                    if (first_beat) begin
                        poly_d   = poly_i;
                        xorout_d = xorout_i;
                    end
                    if (s_axis_tlast) begin
                        state_d     = CRC;
                        crc_out_d   = crc_upd ^ xorout_eff;
                        crc_valid_d = 1'b1;
                        cnt_d       = '0;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            CRC: begin
                if (load_en && (cnt_q != CNTW'(NCRC))) begin
                    m_valid_d = 1'b1;
                    m_data_d  = crc_beat;
                    m_last_d  = (cnt_q == CNTW'(NCRC - 1));
                    cnt_d     = cnt_q + CNTW'(1);
                end
                // Only the final CRC beat ever carries tlast, so its handshake closes the packet.
                if (m_valid_q && m_axis_tready && m_last_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            crc_q       <= '0;
            poly_q      <= '0;
            xorout_q    <= '0;
            crc_out_q   <= '0;
            crc_valid_q <= 1'b0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_last_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            poly_q      <= poly_d;
            xorout_q    <= xorout_d;
            crc_out_q   <= crc_out_d;
            crc_valid_q <= crc_valid_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_last_q    <= m_last_d;
            cnt_q       <= cnt_d;
        end
    end

`ifdef AXIS_CRC_FRAMER_STATS_EN
    logic [31:0] pkt_cnt_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pkt_cnt_q <= '0;
        end else if ((state_q == CRC) && m_valid_q && m_axis_tready && m_last_q) begin
            pkt_cnt_q <= pkt_cnt_q + 32'd1;
        end
    end

    assign pkt_cnt_o = pkt_cnt_q;
`endif

    assign s_axis_tready = s_ready;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tlast  = m_last_q;
    assign crc_o         = crc_out_q;
    assign crc_valid_o   = crc_valid_q;

endmodule

// File: tb/tb_axis_crc_framer.sv
// Scoreboard bench for axis_crc_framer: a CRC-16 and a CRC-32 instance driven with directed packets.
// Stats checks are compiled only when AXIS_CRC_FRAMER_STATS_EN is defined.
module tb_axis_crc_framer;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       c;
    } beat_t;

    logic        clk;
    logic        rstn;

    logic [15:0] p16, i16, x16;
    logic [7:0]  s16_data;
    logic        s16_valid, s16_last, s16_ready;
    logic [7:0]  m16_data;
    logic        m16_valid, m16_last, m16_ready;
    logic [15:0] crc16;
    logic        crcv16;

    logic [31:0] p32, i32, x32;
    logic [7:0]  s32_data;
    logic        s32_valid, s32_last, s32_ready;
    logic [7:0]  m32_data;
    logic        m32_valid, m32_last, m32_ready;
    logic [31:0] crc32;
    logic        crcv32;

`ifdef AXIS_CRC_FRAMER_STATS_EN
    logic [31:0] pkt16, pkt32;
`endif

    beat_t       exp16[$];
    beat_t       exp32[$];
    logic [15:0] crcq16[$];
    logic [31:0] crcq32[$];

    int          n_vec = 0;
    int          n_err = 0;
    bit          rnd   = 0;

    logic [7:0]  s123[$];
    logic [7:0]  one0[$];
    logic [7:0]  s1234[$];

    axis_crc_framer #(.DATA_WIDTH(8), .CRC_WIDTH(16)) u16 (
        .clk_i(clk), .rstn_i(rstn),
        .poly_i(p16), .init_i(i16), .xorout_i(x16),
        .s_axis_tdata(s16_data), .s_axis_tvalid(s16_valid), .s_axis_tlast(s16_last),
        .s_axis_tready(s16_ready),
        .m_axis_tdata(m16_data), .m_axis_tvalid(m16_valid), .m_axis_tlast(m16_last),
        .m_axis_tready(m16_ready),
        .crc_o(crc16), .crc_valid_o(crcv16)
`ifdef AXIS_CRC_FRAMER_STATS_EN
        , .pkt_cnt_o(pkt16)
`endif
    );

    axis_crc_framer #(.DATA_WIDTH(8), .CRC_WIDTH(32)) u32 (
        .clk_i(clk), .rstn_i(rstn),
        .poly_i(p32), .init_i(i32), .xorout_i(x32),
        .s_axis_tdata(s32_data), .s_axis_tvalid(s32_valid), .s_axis_tlast(s32_last),
        .s_axis_tready(s32_ready),
        .m_axis_tdata(m32_data), .m_axis_tvalid(m32_valid), .m_axis_tlast(m32_last),
        .m_axis_tready(m32_ready),
        .crc_o(crc32), .crc_valid_o(crcv32)
`ifdef AXIS_CRC_FRAMER_STATS_EN
        , .pkt_cnt_o(pkt32)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got timeout/unexpected event, want none", name);
    endfunction

    function automatic void push(input bit w32, input logic [7:0] d, input logic l, input logic c);
        beat_t b;
        b.d = d;
        b.l = l;
        b.c = c;
        if (w32) exp32.push_back(b);
        else     exp16.push_back(b);
    endfunction

    // Random downstream backpressure on the CRC-16 instance when rnd is set.
    initial begin
        m16_ready = 1'b1;
        m32_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m16_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every output handshake and on every crc_valid pulse.
    initial begin
        bit         hold16, hold32;
        logic [7:0] hd16, hd32;
        logic       hl16, hl32;
        beat_t      b;
        hold16 = 0; hold32 = 0; hd16 = '0; hd32 = '0; hl16 = 0; hl32 = 0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                hold16 = 0;
                hold32 = 0;
                continue;
            end
            if (hold16) chk("hold16", {m16_valid, m16_data, m16_last}, {1'b1, hd16, hl16});
            if (m16_valid && m16_ready) begin
                if (exp16.size() == 0) fail("extra_beat16");
                else begin
                    b = exp16.pop_front();
                    $display("beat16 data=%02h last=%0d", m16_data, m16_last);
                    chk("beat16", {m16_data, m16_last}, {b.d, b.l});
                    if (b.c) chk("sready16_in_crc", s16_ready, 0);
                end
            end
            hold16 = m16_valid && !m16_ready;
            hd16   = m16_data;
            hl16   = m16_last;
            if (crcv16) begin
                if (crcq16.size() == 0) fail("extra_crc16");
                else chk("crc16", crc16, crcq16.pop_front());
            end

            if (hold32) chk("hold32", {m32_valid, m32_data, m32_last}, {1'b1, hd32, hl32});
            if (m32_valid && m32_ready) begin
                if (exp32.size() == 0) fail("extra_beat32");
                else begin
                    b = exp32.pop_front();
                    $display("beat32 data=%02h last=%0d", m32_data, m32_last);
                    chk("beat32", {m32_data, m32_last}, {b.d, b.l});
                    if (b.c) chk("sready32_in_crc", s32_ready, 0);
                end
            end
            hold32 = m32_valid && !m32_ready;
            hd32   = m32_data;
            hl32   = m32_last;
            if (crcv32) begin
                if (crcq32.size() == 0) fail("extra_crc32");
                else chk("crc32", crc32, crcq32.pop_front());
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic send(input bit w32, input logic [7:0] d, input logic last);
        bit hs;
        int t;
        t = 0;
        if (w32) begin s32_valid = 1'b1; s32_data = d; s32_last = last; end
        else     begin s16_valid = 1'b1; s16_data = d; s16_last = last; end
        do begin
            @(negedge clk);
            hs = w32 ? s32_ready : s16_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!hs && t < 200);
        if (!hs) fail("s_axis_handshake_timeout");
        if (w32) s32_valid = 1'b0;
        else     s16_valid = 1'b0;
    endtask

    task automatic send_pkt(input bit w32, input logic [7:0] bytes[$], input logic [31:0] crc,
                            input bit gap, input bit scr);
        logic [15:0] sp, si, sx;
        for (int i = 0; i < bytes.size(); i++) push(w32, bytes[i], 1'b0, 1'b0);
        if (w32) begin
            push(1'b1, crc[31:24], 1'b0, 1'b1);
            push(1'b1, crc[23:16], 1'b0, 1'b1);
            push(1'b1, crc[15:8],  1'b0, 1'b1);
            push(1'b1, crc[7:0],   1'b1, 1'b1);
            crcq32.push_back(crc);
        end else begin
            push(1'b0, crc[15:8], 1'b0, 1'b1);
            push(1'b0, crc[7:0],  1'b1, 1'b1);
            crcq16.push_back(crc[15:0]);
        end
        sp = p16; si = i16; sx = x16;
        for (int i = 0; i < bytes.size(); i++) begin
            send(w32, bytes[i], i == bytes.size() - 1);
            // Configuration changed mid-packet must not affect the CRC.
            if (scr && i == 0) begin p16 = 16'hBEEF; i16 = 16'h0000; x16 = 16'h5A5A; end
            if (gap) repeat (2) begin @(posedge clk); #1; end
        end
        if (scr) begin p16 = sp; i16 = si; x16 = sx; end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp16.size() + exp32.size() + crcq16.size() + crcq32.size()) != 0 && t < 1000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 1000) fail("drain_timeout");
        repeat (2) begin @(posedge clk); #1; end
    endtask

    initial begin
        for (int i = 1; i <= 9; i++) s123.push_back(8'(8'h30 + i));
        for (int i = 1; i <= 4; i++) s1234.push_back(8'(8'h30 + i));
        one0.push_back(8'h00);

        rstn = 1'b0;
        p16 = 16'h1021; i16 = 16'hFFFF; x16 = 16'h0000;
        p32 = 32'h04C11DB7; i32 = 32'hFFFFFFFF; x32 = 32'h0;
        s16_valid = 0; s16_data = '0; s16_last = 0;
        s32_valid = 0; s32_data = '0; s32_last = 0;

        #22;
        chk("rst_m16_valid", m16_valid, 0);
        chk("rst_m16_data",  m16_data,  0);
        chk("rst_m16_last",  m16_last,  0);
        chk("rst_s16_ready", s16_ready, 0);
        chk("rst_crc16",     crc16,     0);
        chk("rst_crcv16",    crcv16,    0);
        chk("rst_m32_valid", m32_valid, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("s16_ready_after_reset", s16_ready, 1);

        // CRC-16/CCITT-FALSE and CRC-32/MPEG-2 check strings.
        send_pkt(1'b0, s123, 32'h29B1, 1'b0, 1'b0);
        send_pkt(1'b1, s123, 32'h0376E6E7, 1'b0, 1'b0);
        drain();

        // Single-beat packet: one payload beat plus two CRC beats.
        send_pkt(1'b0, one0, 32'hE1F0, 1'b0, 1'b0);
        drain();
        chk("s16_ready_after_single", s16_ready, 1);

        // xorout applied, tvalid gaps mid-packet, config disturbed after the first beat.
        x16 = 16'hFFFF;
        send_pkt(1'b0, s123, 32'hD64E, 1'b1, 1'b1);
        drain();

        // Back-to-back packets under random downstream backpressure.
        rnd = 1;
        x16 = 16'h0000; send_pkt(1'b0, s123, 32'h29B1, 1'b0, 1'b0);
        x16 = 16'h0000; send_pkt(1'b0, one0, 32'hE1F0, 1'b0, 1'b0);
        x16 = 16'hFFFF; send_pkt(1'b0, s123, 32'hD64E, 1'b0, 1'b0);
        x16 = 16'hFFFF; send_pkt(1'b0, one0, 32'h1E0F, 1'b0, 1'b0);
        drain();
        rnd = 0;
        x16 = 16'h0000;

        // Reset part-way through a packet discards it.
        for (int i = 0; i < s1234.size(); i++) begin
            push(1'b0, s1234[i], 1'b0, 1'b0);
            send(1'b0, s1234[i], 1'b0);
        end
        #2;
        rstn = 1'b0;
        #1;
        chk("midrst_m16_valid", m16_valid, 0);
        chk("midrst_m16_data",  m16_data,  0);
        chk("midrst_s16_ready", s16_ready, 0);
        chk("midrst_crc16",     crc16,     0);
        exp16.delete();
        crcq16.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("s16_ready_after_midrst", s16_ready, 1);
        send_pkt(1'b0, s123, 32'h29B1, 1'b0, 1'b0);
        drain();

`ifdef AXIS_CRC_FRAMER_STATS_EN
        chk("pkt_cnt_1", pkt16, 1);
        send_pkt(1'b0, one0, 32'hE1F0, 1'b0, 1'b0);
        send_pkt(1'b0, s123, 32'h29B1, 1'b0, 1'b0);
        drain();
        chk("pkt_cnt_3", pkt16, 3);
        @(negedge clk);
        force u16.pkt_cnt_q = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        release u16.pkt_cnt_q;
        chk("pkt_cnt_forced", pkt16, 32'hFFFFFFFF);
        send_pkt(1'b0, one0, 32'hE1F0, 1'b0, 1'b0);
        drain();
        chk("pkt_cnt_wrap", pkt16, 0);
`endif

        chk("exp16_empty", exp16.size(), 0);
        chk("crcq16_empty", crcq16.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
